midi_tx: RTL and testbench

MIDI_TX -- requirements
Module: midi_tx

---
 rtl/midi_tx.sv | 175 +++++++++++++++++
 tb/tb_midi_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI serial transmitter with running-status compression
module midi_tx #(
    parameter int CLKFREQ = 24576000,
    parameter int SPEED   = 31250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] status,
    input  logic [6:0] data1,
    input  logic [6:0] data2,
    input  logic       running_status_en,
    output logic       midi_out,
    output logic       busy
);
    localparam int DIV = CLKFREQ / SPEED;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    // Bytes still to send, byte 0 in the low bits; shifted one bit per data bit
    // so that after a full byte the next byte lands in the low bits.
    logic [23:0]   msg_q, msg_d;
    logic [1:0]    left_q, left_d;
    logic          out_q, out_d;
    logic [7:0]    rs_q, rs_d;
    logic          rs_ok_q, rs_ok_d;

    logic       accept;
    logic       is_chan;
    logic       is_rt;
    logic       omit;
    logic       bit_end;
    logic [1:0] len;

    assign accept  = msg_valid && (state_q == S_IDLE);
    assign is_chan = status[7] && (status[7:4] != 4'hF);
    assign is_rt   = (status[7:3] == 5'b11111);
    assign omit    = running_status_en && is_chan && rs_ok_q && (rs_q == status);
    assign bit_end = (cnt_q == CNT_MAX);

    // Message length from the status byte; zero means "not a status, drop it".
    always_comb begin
        len = 2'd0;
        if (status[7]) begin
            case (status[7:4])
                4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd3;
                4'hC, 4'hD:                   len = 2'd2;
                default: begin
                    case (status[3:0])
                        4'h1, 4'h3: len = 2'd2;
                        4'h2:       len = 2'd3;
                        default:    len = 2'd1;
                    endcase
                end
            endcase
        end
    end

    // Frame sequencing, running-status tracking and next line level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        msg_d   = msg_q;
        left_d  = left_q;
        out_d   = out_q;
        rs_d    = rs_q;
        rs_ok_d = rs_ok_q;
        case (state_q)
            S_IDLE: begin
                out_d = 1'b1;
                cnt_d = '0;
                bit_d = 3'd0;
                if (accept && status[7]) begin
                    if (is_chan) begin
                        rs_d    = status;
                        rs_ok_d = 1'b1;
                    end else if (!is_rt) begin
                        rs_ok_d = 1'b0;
                    end
                    if (omit) begin
                        msg_d  = {8'h00, 1'b0, data2, 1'b0, data1};
                        left_d = len - 2'd1;
                    end else begin
                        msg_d  = {1'b0, data2, 1'b0, data1, status};
                        left_d = len;
                    end
                    state_d = S_START;
                    out_d   = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    out_d   = msg_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    msg_d = {1'b0, msg_q[23:1]};
                    if (bit_q == 3'd7) begin
                        out_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        out_d = msg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (left_q > 2'd1) begin
                        left_d  = left_q - 2'd1;
                        out_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        left_d  = 2'd0;
                        out_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any frame and forgets running status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            msg_q   <= 24'h0;
            left_q  <= 2'd0;
            out_q   <= 1'b1;
            rs_q    <= 8'h00;
            rs_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            msg_q   <= msg_d;
            left_q  <= left_d;
            out_q   <= out_d;
            rs_q    <= rs_d;
            rs_ok_q <= rs_ok_d;
        end
    end

    assign midi_out  = out_q;
    assign msg_ready = (state_q == S_IDLE);
    assign busy      = !msg_ready;

endmodule

// File: tb/tb_midi_tx.sv
// tb/tb_midi_tx.sv - self-checking bench for midi_tx
module tb_midi_tx;
    // 1234/100 truncates to 12 cycles per bit
    localparam int T_CLKFREQ = 1234;
    localparam int T_SPEED   = 100;
    localparam int DIV       = 12;
    localparam int DIV_DEF   = 786;

    logic       clk = 1'b0;
    logic       rst;
    logic       msg_valid;
    logic       msg_valid_def;
    logic [7:0] status;
    logic [6:0] data1;
    logic [6:0] data2;
    logic       running_status_en;
    logic       msg_ready, midi_out, busy;
    logic       msg_ready_def, midi_out_def, busy_def;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    midi_tx #(.CLKFREQ(T_CLKFREQ), .SPEED(T_SPEED)) dut (
        .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .status(status), .data1(data1), .data2(data2),
        .running_status_en(running_status_en), .midi_out(midi_out), .busy(busy)
    );

    midi_tx dut_def (
        .clk(clk), .rst(rst), .msg_valid(msg_valid_def), .msg_ready(msg_ready_def),
        .status(status), .data1(data1), .data2(data2),
        .running_status_en(running_status_en), .midi_out(midi_out_def), .busy(busy_def)
    );

    typedef struct {
        logic [7:0] st;
        logic [6:0] d1;
        logic [6:0] d2;
        logic       en;
        int         n;
    } vec_t;
    vec_t tbl[$];

    // reference model: running-status memory and the bytes of the current message
    logic [7:0] m_rs;
    logic       m_rs_ok;
    logic [7:0] mb[3];
    int         mn;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int msg_len(input logic [7:0] s);
        if (s < 8'h80) return 0;
        if (s < 8'hC0) return 3;
        if (s < 8'hE0) return 2;
        if (s < 8'hF0) return 3;
        if (s == 8'hF1 || s == 8'hF3) return 2;
        if (s == 8'hF2) return 3;
        return 1;
    endfunction

    task automatic model(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2, input logic en);
        logic [7:0] all_b[3];
        int n;
        int skip;
        all_b[0] = st;
        all_b[1] = {1'b0, d1};
        all_b[2] = {1'b0, d2};
        n = msg_len(st);
        skip = 0;
        if (n > 0) begin
            if (st < 8'hF0) begin
                if (en && m_rs_ok && m_rs == st) skip = 1;
                m_rs = st;
                m_rs_ok = 1'b1;
            end else if (st < 8'hF8) begin
                m_rs_ok = 1'b0;
            end
        end
        mn = n - skip;
        for (int i = 0; i < 3; i++) mb[i] = (i + skip < 3) ? all_b[i + skip] : 8'h00;
    endtask

    function automatic logic exp_line(input int c);
        int k;
        int p;
        logic [7:0] b;
        if (c >= 10 * DIV * mn) return 1'b1;
        k = c / (10 * DIV);
        p = (c % (10 * DIV)) / DIV;
        b = mb[k];
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    // Called one step after the accepting edge; follows the frame until busy drops.
    task automatic watch(input int exp_n, input string name);
        int c = 0;
        int mism = 0;
        int busy_cnt = 0;
        while (busy === 1'b1 && c < 40 * DIV) begin
            if (midi_out !== exp_line(c) || msg_ready !== 1'b0) begin
                if (mism == 0) $display("  %s: first line difference at cycle %0d", name, c + 1);
                mism++;
            end
            busy_cnt++;
            c++;
            @(posedge clk); #1;
        end
        check({name, ".wave"}, mism, 0);
        check({name, ".busy_len"}, busy_cnt, 10 * DIV * exp_n);
        check({name, ".ready_back"}, int'(msg_ready), 1);
        check({name, ".idle_line"}, int'(midi_out), 1);
    endtask

    task automatic send(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2,
                        input logic en, input int exp_n, input string name);
        int w = 0;
        int n;
        while (msg_ready !== 1'b1 && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        check({name, ".ready_wait"}, int'(msg_ready), 1);
        model(st, d1, d2, en);
        n = (exp_n < 0) ? mn : exp_n;
        status = st; data1 = d1; data2 = d2; running_status_en = en;
        msg_valid = 1'b1;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        status = 8'h00; data1 = 7'h00; data2 = 7'h00;
        watch(n, name);
    endtask

    task automatic add(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2,
                       input logic en, input int n);
        vec_t v;
        v.st = st; v.d1 = d1; v.d2 = d2; v.en = en; v.n = n;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] chans[5];
        logic [7:0] st;
        logic [7:0] got;
        int mism;
        int c;
        int busy_cnt;
        int pick;

        chans[0] = 8'h90; chans[1] = 8'h91; chans[2] = 8'hC5; chans[3] = 8'hE0; chans[4] = 8'hB3;
        msg_valid = 1'b0; msg_valid_def = 1'b0;
        status = 8'h00; data1 = 7'h00; data2 = 7'h00; running_status_en = 1'b0;
        m_rs = 8'h00; m_rs_ok = 1'b0; mn = 0;
        for (int i = 0; i < 3; i++) mb[i] = 8'h00;

        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset.midi_out", int'(midi_out), 1);
        check("reset.msg_ready", int'(msg_ready), 1);
        check("reset.busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        add(8'h90, 7'h3C, 7'h64, 1'b1, 3);
        add(8'h90, 7'h3E, 7'h00, 1'b1, 2);
        add(8'h80, 7'h3C, 7'h00, 1'b1, 3);
        add(8'h90, 7'h3C, 7'h64, 1'b1, 3);
        add(8'hF8, 7'h00, 7'h00, 1'b1, 1);
        add(8'h90, 7'h40, 7'h10, 1'b1, 2);
        add(8'hC5, 7'h07, 7'h00, 1'b1, 2);
        add(8'hF2, 7'h01, 7'h02, 1'b1, 3);
        add(8'hC5, 7'h08, 7'h00, 1'b1, 2);
        add(8'hC5, 7'h09, 7'h00, 1'b0, 2);
        add(8'hC5, 7'h0A, 7'h00, 1'b1, 1);
        add(8'h3C, 7'h11, 7'h22, 1'b1, 0);
        add(8'hC5, 7'h0B, 7'h00, 1'b1, 1);
        add(8'hF1, 7'h05, 7'h00, 1'b1, 2);
        add(8'hC5, 7'h0B, 7'h00, 1'b1, 2);
        add(8'hE0, 7'h01, 7'h7F, 1'b1, 3);
        add(8'hE0, 7'h02, 7'h7F, 1'b1, 2);
        add(8'hFF, 7'h00, 7'h00, 1'b1, 1);
        add(8'hE0, 7'h03, 7'h00, 1'b1, 2);
        add(8'hF6, 7'h00, 7'h00, 1'b1, 1);
        add(8'hE0, 7'h04, 7'h00, 1'b1, 3);
        add(8'hF3, 7'h07, 7'h00, 1'b1, 2);
        add(8'hB0, 7'h07, 7'h7F, 1'b0, 3);
        add(8'hD0, 7'h10, 7'h00, 1'b1, 2);
        add(8'hF0, 7'h00, 7'h00, 1'b1, 1);
        for (int i = 0; i < tbl.size(); i++)
            send(tbl[i].st, tbl[i].d1, tbl[i].d2, tbl[i].en, tbl[i].n, $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            pick = $urandom_range(0, 9);
            if (pick <= 4)      st = chans[pick];
            else if (pick == 5) st = 8'hF8 | 8'($urandom_range(0, 7));
            else if (pick == 6) st = 8'hF0 | 8'($urandom_range(0, 7));
            else if (pick == 7) st = 8'($urandom_range(0, 127));
            else                st = m_rs_ok ? m_rs : chans[0];
            send(st, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                 ($urandom_range(0, 3) != 0), -1, $sformatf("rnd%0d", i));
        end

        // non-status dropped while valid stays high, then a real message follows
        status = 8'h3C; data1 = 7'h01; data2 = 7'h02; running_status_en = 1'b1;
        msg_valid = 1'b1;
        @(posedge clk); #1;
        check("drop.midi_out", int'(midi_out), 1);
        check("drop.msg_ready", int'(msg_ready), 1);
        model(8'h90, 7'h3C, 7'h64, 1'b0);
        status = 8'h90; data1 = 7'h3C; data2 = 7'h64; running_status_en = 1'b0;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        check("drop.next_start", int'(midi_out), 0);
        watch(3, "drop.next");

        // reset in the middle of a note-on frame
        model(8'h90, 7'h3C, 7'h64, 1'b0);
        status = 8'h90; data1 = 7'h3C; data2 = 7'h64; running_status_en = 1'b0;
        msg_valid = 1'b1;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        check("abort.line_low_before", int'(midi_out), 0);
        rst = 1'b1;
        #1;
        check("abort.midi_out", int'(midi_out), 1);
        check("abort.msg_ready", int'(msg_ready), 1);
        check("abort.busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_rs_ok = 1'b0;
        mism = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            if (midi_out !== 1'b1 || busy !== 1'b0) mism++;
            @(posedge clk); #1;
        end
        check("abort.no_resume", mism, 0);
        send(8'h90, 7'h3C, 7'h64, 1'b1, 3, "abort.after");

        // default-rate instance: note-on frame timing
        status = 8'h90; data1 = 7'h3C; data2 = 7'h64; running_status_en = 1'b1;
        msg_valid_def = 1'b1;
        @(posedge clk); #1;
        msg_valid_def = 1'b0;
        c = 0; busy_cnt = 0; mism = 0;
        got = 8'h00;
        while (busy_def === 1'b1 && c < 30000) begin
            if (c % DIV_DEF == DIV_DEF / 2) begin
                pick = (c % (10 * DIV_DEF)) / DIV_DEF;
                if (pick == 0 && midi_out_def !== 1'b0) mism++;
                else if (pick == 9 && midi_out_def !== 1'b1) mism++;
                else if (pick >= 1 && pick <= 8) got[pick-1] = midi_out_def;
                if (pick == 8) begin
                    case (c / (10 * DIV_DEF))
                        0: check("def.byte0", int'(got), 8'h90);
                        1: check("def.byte1", int'(got), 8'h3C);
                        default: check("def.byte2", int'(got), 8'h64);
                    endcase
                end
            end
            busy_cnt++;
            c++;
            @(posedge clk); #1;
        end
        check("def.framing", mism, 0);
        check("def.busy_len", busy_cnt, 23580);
        check("def.ready_back", int'(msg_ready_def), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
